// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequences every write into the HI/LO register pair.
// Handles MULT/MULTU (fixed-latency multiply), DIV/DIVU (32-step restoring
// divide), MTHI and MTLO, stalls EX while busy and issues a registered
// one-cycle 64-bit {HI,LO} write.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT        = 2,     // accept-to-write cycles for MULT/MULTU, 1..4
    parameter bit DIV_ZERO_WRITE = 1'b1   // zero divisor writes {rs, all-ones} when set
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic [63:0] hilo_rd,
    output logic        stall,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic        hilo_we_q, hilo_we_d;
    logic [63:0] hilo_wdata_q, hilo_wdata_d;

    logic        op_legal, is_long, accept, mul_signed, div_signed;
    logic [32:0] mul_a, mul_b;
    logic [63:0] prod;
    logic [32:0] div_shift, div_diff;
    logic        div_fit;
    logic [31:0] rem_n, quo_n;

    assign op_legal   = (op != 3'b000) && (op != 3'b111);
    assign is_long    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign accept     = (state_q == IDLE) && op_valid && op_legal && !flush;
    assign mul_signed = (op == OP_MULT);
    assign div_signed = (op == OP_DIV);

    assign stall = (state_q != IDLE) | (accept & is_long);

    // Multiplier operands come straight from the ports in IDLE so MUL_LAT=1 needs no extra state.
    assign mul_a = (state_q == IDLE) ? {mul_signed & rs_val[31], rs_val} : mul_a_q;
    assign mul_b = (state_q == IDLE) ? {mul_signed & rt_val[31], rt_val} : mul_b_q;
    assign prod  = 64'($signed(mul_a)) * 64'($signed(mul_b));

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign div_fit   = ~div_diff[32];
    assign rem_n     = div_fit ? div_diff[31:0] : div_shift[31:0];
    assign quo_n     = {quo_q[30:0], div_fit};

    // Next-state, operand latching and write-strobe generation.
    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        hilo_we_d    = 1'b0;
        hilo_wdata_d = hilo_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_MTHI: begin
                            hilo_we_d    = 1'b1;
                            hilo_wdata_d = {rs_val, hilo_rd[31:0]};
                        end
                        OP_MTLO: begin
                            hilo_we_d    = 1'b1;
                            hilo_wdata_d = {hilo_rd[63:32], rs_val};
                        end
                        OP_MULT, OP_MULTU: begin
                            mul_a_d = mul_a;
                            mul_b_d = mul_b;
                            if (MUL_LAT <= 1) begin
                                hilo_we_d    = 1'b1;
                                hilo_wdata_d = prod;
                            end else begin
                                state_d = MUL;
                                cnt_d   = 6'd1;
                            end
                        end
                        default: begin  // DIV / DIVU
                            if (rt_val == 32'd0) begin
                                if (DIV_ZERO_WRITE) begin
                                    hilo_we_d    = 1'b1;
                                    hilo_wdata_d = {rs_val, 32'hFFFF_FFFF};
                                end
                            end else begin
                                quo_d   = (div_signed & rs_val[31]) ? -rs_val : rs_val;
                                dvs_d   = (div_signed & rt_val[31]) ? -rt_val : rt_val;
                                rem_d   = 32'd0;
                                q_neg_d = div_signed & (rs_val[31] ^ rt_val[31]);
                                r_neg_d = div_signed & rs_val[31];
                                cnt_d   = 6'd0;
                                state_d = DIV;
                            end
                        end
                    endcase
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'(MUL_LAT - 1)) begin
                    hilo_we_d    = 1'b1;
                    hilo_wdata_d = prod;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    quo_d = quo_n;
                    rem_d = rem_n;
                    if (cnt_q == 6'd31) begin
                        hilo_we_d    = 1'b1;
                        hilo_wdata_d = {r_neg_q ? -rem_n : rem_n, q_neg_q ? -quo_n : quo_n};
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            hilo_we_q    <= 1'b0;
            hilo_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            hilo_we_q    <= hilo_we_d;
            hilo_wdata_q <= hilo_wdata_d;
        end
    end

    assign hilo_we    = hilo_we_q;
    assign hilo_wdata = hilo_wdata_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Testbench for hilo_muldiv_ctrl: scoreboard of expected {cycle, data} writes,
// plus per-scenario stall and no-write checks.
module tb_hilo_muldiv_ctrl;

    localparam int MUL_LAT = 2;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        flush;
    logic [63:0] hilo_rd;
    logic        stall, hilo_we;
    logic [63:0] hilo_wdata;
    logic        stall_nz, hilo_we_nz;
    logic [63:0] hilo_wdata_nz;

    typedef struct {
        int          cyc;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   dz_window = 1'b0;
    int   dz1_writes = 0;

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ZERO_WRITE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .flush(flush), .hilo_rd(hilo_rd), .stall(stall),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata)
    );

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ZERO_WRITE(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .rs_val(rs_val),
        .rt_val(rt_val), .flush(flush), .hilo_rd(hilo_rd), .stall(stall_nz),
        .hilo_we(hilo_we_nz), .hilo_wdata(hilo_wdata_nz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match the head of the queue in data and cycle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && hilo_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cyc=%0d data=%h", cyc, hilo_wdata);
            end else begin
                e = sb.pop_front();
                if (hilo_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write got data=%h cyc=%0d expected data=%h cyc=%0d",
                             hilo_wdata, cyc, e.data, e.cyc);
                end
            end
        end
        if (dz_window && hilo_we_nz === 1'b1) dz1_writes++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int stall_cycles(input logic [2:0] o, input logic [31:0] b);
        if (o == OP_MULT || o == OP_MULTU) return MUL_LAT;
        if (o == OP_DIV || o == OP_DIVU) return (b == 32'd0) ? 1 : 33;
        return 0;
    endfunction

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hr);
        logic signed [31:0] da, db, q, r;
        longint p;
        da = a;
        db = b;
        case (o)
            OP_MULT: begin
                p = longint'(da) * longint'(db);
                return p;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = da / db;
                r = da % db;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_MTHI: return {a, hr[31:0]};
            default: return {hr[63:32], a};
        endcase
    endfunction

    // Offer one op at the current cycle, check stall each cycle; returns in its write cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] d, input string name);
        int sc, n, c0;
        exp_t e;
        sc = stall_cycles(o, b);
        n  = (sc > 0) ? sc : 1;
        c0 = cyc;
        e.cyc  = c0 + n;
        e.data = d;
        sb.push_back(e);
        op_valid = 1'b1;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if (stall !== (k < sc)) begin
                errors++;
                $display("FAIL %s_stall cycle=%0d got=%b expected=%b", name, k, stall, (k < sc));
            end
            step();
            if (k == 0) op_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall_at_write got=%b expected=0", name, stall);
        end
        step();
        n = 0;
        while (sb.size() != 0 && n < 8) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_write_timeout pending=%0d expected=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic expect_no_write(input int ncyc, input string name);
        int bad;
        bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (hilo_we !== 1'b0 || stall !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s got %0d cycles with write/stall expected=0", name, bad);
        end
    endtask

    task automatic test_reset();
        #3;
        checks += 3;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b expected=0", stall); end
        if (hilo_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b expected=0", hilo_we); end
        if (hilo_wdata !== 64'd0) begin errors++; $display("FAIL reset_wdata got=%h expected=0", hilo_wdata); end
        step();
        rst_n = 1'b1;
        expect_no_write(2, "post_reset_idle");
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, "mult");
        drain("mult");
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, "multu");
        drain("multu");
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div");
        drain("div");
        run_op(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "divu");
        drain("divu");
    endtask

    task automatic test_div_edge();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_ovf");
        drain("div_ovf");
        dz_window  = 1'b1;
        dz1_writes = 0;
        run_op(OP_DIVU, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, "divu_zero");
        drain("divu_zero");
        run_op(OP_DIV, 32'hFFFF_FFFD, 32'd0, 64'hFFFF_FFFD_FFFF_FFFF, "div_zero");
        drain("div_zero");
        dz_window = 1'b0;
        checks++;
        if (dz1_writes != 0) begin
            errors++;
            $display("FAIL div_zero_nowrite got=%0d writes expected=0", dz1_writes);
        end
    endtask

    task automatic test_mthi_mtlo();
        hilo_rd = 64'hAAAA_AAAA_BBBB_BBBB;
        run_op(OP_MTHI, 32'h1234_5678, 32'd0, 64'h1234_5678_BBBB_BBBB, "mthi");
        run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, 64'hAAAA_AAAA_9ABC_DEF0, "mtlo");
        drain("mtlo");
    endtask

    task automatic test_illegal();
        op_valid = 1'b1;
        op       = 3'b000;
        step();
        op = 3'b111;
        step();
        op_valid = 1'b0;
        expect_no_write(4, "illegal_op");
    endtask

    task automatic test_flush();
        // Flush on the offer cycle: never accepted.
        op_valid = 1'b1;
        op       = OP_MULT;
        rs_val   = 32'd9;
        rt_val   = 32'd9;
        flush    = 1'b1;
        step();
        op_valid = 1'b0;
        flush    = 1'b0;
        expect_no_write(4, "flush_at_accept");
        // Flush at cycle 10 of a DIV, then a MULT at cycle 11.
        op_valid = 1'b1;
        op       = OP_DIV;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        step();
        op_valid = 1'b0;
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL flush_cycle_stall got=%b expected=1", stall); end
        step();
        flush = 1'b0;
        run_op(OP_MULT, 32'd6, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, "mult_after_flush");
        drain("mult_after_flush");
        expect_no_write(30, "flushed_div_nowrite");
    endtask

    task automatic test_reset_mid();
        int bad;
        op_valid = 1'b1;
        op       = OP_DIV;
        rs_val   = 32'hFFFF_FFF9;
        rt_val   = 32'd2;
        step();
        op_valid = 1'b0;
        for (int k = 1; k < 5; k++) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (stall !== 1'b0) begin errors++; $display("FAIL midreset_stall got=%b expected=0", stall); end
        if (hilo_we !== 1'b0) begin errors++; $display("FAIL midreset_we got=%b expected=0", hilo_we); end
        if (hilo_wdata !== 64'd0) begin errors++; $display("FAIL midreset_wdata got=%h expected=0", hilo_wdata); end
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (hilo_we !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_nowrite got=%0d writes expected=0", bad); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, "b2b_first");
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, "b2b_second");
        run_op(OP_MULTU, 32'd7, 32'd8, 64'd56, "b2b_third");
        drain("b2b");
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            o       = 3'($urandom_range(1, 6));
            a       = $urandom;
            b       = $urandom >> $urandom_range(0, 31);
            hilo_rd = {$urandom, $urandom};
            if (b == 32'd0) b = 32'd1;
            run_op(o, a, b, model(o, a, b, hilo_rd), "random");
            drain("random");
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op       = 3'b000;
        rs_val   = '0;
        rt_val   = '0;
        flush    = 1'b0;
        hilo_rd  = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
